// File: rtl/keypad_scan_4x4.sv
// rtl/keypad_scan_4x4.sv - 4x4 matrix keypad scanner with frame debounce and single-key press detect
// Drives one active-low row per clk_200hz cycle and accepts a frame after DEBOUNCE_SCANS repeats.
module keypad_scan_4x4 #(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic        clk_200hz,
  input  logic        rst_n_in,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic [15:0] key_out,
  output logic        key_press,
  output logic [3:0]  key_code
);

  typedef enum logic [1:0] {ROW0, ROW1, ROW2, ROW3} scan_state_t;

  localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

  scan_state_t state;
  logic [11:0] raw;
  logic [15:0] frame_prev;
  logic [3:0]  cnt;

  logic [15:0] new_frame;
  logic [3:0]  cnt_next;
  logic [4:0]  zero_cnt;
  logic [3:0]  zero_idx;
  logic        one_zero;

  // Row 3 is never stored in raw: the frame is assembled straight from col_in on the edge leaving ROW3.
  always_comb begin
    new_frame = {col_in, raw};
    if (new_frame == frame_prev) begin
      cnt_next = (cnt >= DEB) ? DEB : cnt + 4'd1;
    end else begin
      cnt_next = 4'd1;
    end
    zero_cnt = 5'd0;
    zero_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (!new_frame[i]) begin
        zero_cnt = zero_cnt + 5'd1;
        zero_idx = 4'(i);
      end
    end
    one_zero = (zero_cnt == 5'd1);
  end

  always_ff @(posedge clk_200hz or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= ROW0;
      row_out    <= 4'b1110;
      raw        <= 12'hFFF;
      frame_prev <= 16'hFFFF;
      cnt        <= 4'd0;
      key_out    <= 16'hFFFF;
      key_press  <= 1'b0;
      key_code   <= 4'd0;
    end else begin
      key_press <= 1'b0;
      unique case (state)
        ROW0: begin
          raw[3:0] <= col_in;
          state    <= ROW1;
          row_out  <= 4'b1101;
        end
        ROW1: begin
          raw[7:4] <= col_in;
          state    <= ROW2;
          row_out  <= 4'b1011;
        end
        ROW2: begin
          raw[11:8] <= col_in;
          state     <= ROW3;
          row_out   <= 4'b0111;
        end
        ROW3: begin
          state      <= ROW0;
          row_out    <= 4'b1110;
          frame_prev <= new_frame;
          cnt        <= cnt_next;
          if (cnt_next == DEB && new_frame != key_out) begin
            key_out <= new_frame;
            // Only a press from the idle state counts; chords and key-to-key slides do not.
            if (key_out == 16'hFFFF && one_zero) begin
              key_press <= 1'b1;
              key_code  <= zero_idx;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// tb/tb_keypad_scan_4x4.sv - scoreboard bench for keypad_scan_4x4
// A keypad model drives col_in from row_out; a negedge monitor checks each key_out/key_press event.
module tb_keypad_scan_4x4;

  logic        clk_200hz = 1'b0;
  logic        rst_n_in;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [15:0] key_out;
  logic        key_press;
  logic [3:0]  key_code;
  logic [15:0] keys;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [15:0] key;
    logic        press;
    logic [3:0]  code;
  } exp_t;
  exp_t exp_q[$];

  keypad_scan_4x4 #(.DEBOUNCE_SCANS(3)) dut (
    .clk_200hz (clk_200hz),
    .rst_n_in  (rst_n_in),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_out   (key_out),
    .key_press (key_press),
    .key_code  (key_code)
  );

  always #5 clk_200hz = ~clk_200hz;
  always @(posedge clk_200hz) cyc <= cyc + 1;

  always_comb begin
    col_in = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && keys[4*r+c]) col_in[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_event(input int c, input logic [15:0] k, input logic p, input logic [3:0] code);
    exp_t e;
    e.cyc = c;
    e.key = k;
    e.press = p;
    e.code = code;
    exp_q.push_back(e);
  endtask

  task automatic wait_row(input logic [3:0] pattern);
    int n;
    n = 0;
    do begin
      @(negedge clk_200hz);
      n++;
    end while (row_out !== pattern && n < 8);
    check("row_align", row_out, pattern);
  endtask

  logic [15:0] prev_key = 16'hFFFF;
  always @(negedge clk_200hz) begin
    exp_t e;
    if (rst_n_in === 1'b1 && (key_out !== prev_key || key_press !== 1'b0)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: key_out %h key_press %b key_code %0d at cycle %0d, required no event",
                 key_out, key_press, key_code, cyc);
      end else begin
        e = exp_q.pop_front();
        check("event_cycle", cyc, e.cyc);
        check("event_key_out", key_out, e.key);
        check("event_key_press", key_press, e.press);
        check("event_key_code", key_code, e.code);
      end
    end
    prev_key = key_out;
  end

  logic [3:0] seq [4];
  int c0;

  initial begin
    seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011; seq[3] = 4'b0111;
    keys = 16'h0000;
    rst_n_in = 1'b0;
    repeat (2) @(negedge clk_200hz);
    check("rst_row_out", row_out, 4'b1110);
    check("rst_key_out", key_out, 16'hFFFF);
    check("rst_key_press", key_press, 1'b0);
    check("rst_key_code", key_code, 4'd0);
    rst_n_in = 1'b1;
    check("row_seq_start", row_out, seq[0]);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_200hz);
      check("row_seq", row_out, seq[(i+1)%4]);
    end

    // Asynchronous reset mid-scan
    @(negedge clk_200hz);
    #2 rst_n_in = 1'b0;
    #1 check("async_rst_row_out", row_out, 4'b1110);
    check("async_rst_key_out", key_out, 16'hFFFF);
    @(negedge clk_200hz);
    @(negedge clk_200hz);
    rst_n_in = 1'b1;
    repeat (24) @(negedge clk_200hz);

    // Single press of key 6 from a frame boundary, then release
    wait_row(4'b1110);
    c0 = cyc;
    keys = 16'h0040;
    expect_event(c0 + 12, 16'hFFBF, 1'b1, 4'd6);
    repeat (40) @(negedge clk_200hz);
    wait_row(4'b1110);
    c0 = cyc;
    keys = 16'h0000;
    expect_event(c0 + 12, 16'hFFFF, 1'b0, 4'd6);
    repeat (24) @(negedge clk_200hz);

    // Bounce: key 6 alternating per frame, never stable long enough
    wait_row(4'b1110);
    for (int i = 0; i < 10; i++) begin
      keys = (i % 2 == 0) ? 16'h0040 : 16'h0000;
      repeat (4) @(negedge clk_200hz);
    end
    repeat (24) @(negedge clk_200hz);
    check("bounce_key_out", key_out, 16'hFFFF);
    check("bounce_code_hold", key_code, 4'd6);

    // Chord of keys 0 and 15, then release
    wait_row(4'b1110);
    c0 = cyc;
    keys = 16'h8001;
    expect_event(c0 + 12, 16'h7FFE, 1'b0, 4'd6);
    repeat (24) @(negedge clk_200hz);
    wait_row(4'b1110);
    c0 = cyc;
    keys = 16'h0000;
    expect_event(c0 + 12, 16'hFFFF, 1'b0, 4'd6);
    repeat (24) @(negedge clk_200hz);

    // Press arriving after its row was sampled: partial frame adds latency
    wait_row(4'b1011);
    c0 = cyc;
    keys = 16'h0040;
    expect_event(c0 + 14, 16'hFFBF, 1'b1, 4'd6);
    repeat (24) @(negedge clk_200hz);
    wait_row(4'b1110);
    c0 = cyc;
    keys = 16'h0000;
    expect_event(c0 + 12, 16'hFFFF, 1'b0, 4'd6);
    repeat (24) @(negedge clk_200hz);

    // Reset after two stable frames of key 5; debounce restarts from scratch
    wait_row(4'b1110);
    keys = 16'h0020;
    repeat (8) @(negedge clk_200hz);
    rst_n_in = 1'b0;
    #1 check("mid_debounce_rst_key_out", key_out, 16'hFFFF);
    check("mid_debounce_rst_key_code", key_code, 4'd0);
    @(negedge clk_200hz);
    rst_n_in = 1'b1;
    c0 = cyc;
    expect_event(c0 + 12, 16'hFFDF, 1'b1, 4'd5);
    repeat (20) @(negedge clk_200hz);
    check("key5_held_key_out", key_out, 16'hFFDF);

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
